// File: rtl/led_pwm_array.sv
// led_pwm_array: multi-channel LED PWM with static, breathe and blink modes.
// All channels share one PWM counter and one fade timebase, so their outputs stay phase-aligned.
module led_pwm_array #(
    parameter int NUM_CH = 4,
    parameter int PWM_BITS = 8,
    parameter int FADE_DIV = 16,
    localparam int CH_W = NUM_CH > 1 ? $clog2(NUM_CH) : 1,
    localparam int FD_W = FADE_DIV > 1 ? $clog2(FADE_DIV) : 1
) (
    input  logic                clk,
    input  logic                rst_n,
    input  logic                ena,
    input  logic                wr_en,
    input  logic [CH_W-1:0]     wr_ch,
    input  logic [1:0]          wr_mode,
    input  logic [PWM_BITS-1:0] wr_level,
    output logic [NUM_CH-1:0]   led_out,
    output logic                period_tick
);
    logic [PWM_BITS-1:0] cnt;
    logic [FD_W-1:0]     fdiv;
    logic                wrap;
    logic                fade_step;

    always_comb begin
        wrap      = ena && cnt == '1;
        fade_step = wrap && fdiv == FD_W'(FADE_DIV - 1);
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            cnt         <= '0;
            fdiv        <= '0;
            period_tick <= 1'b0;
        end else begin
            period_tick <= wrap;
            if (ena)
                cnt <= cnt + 1'b1;
            if (wrap)
                fdiv <= fdiv == FD_W'(FADE_DIV - 1) ? '0 : fdiv + 1'b1;
        end
    end

    for (genvar g = 0; g < NUM_CH; g++) begin : ch
        logic [1:0]          mode;
        logic [PWM_BITS-1:0] level;
        logic [PWM_BITS-1:0] phase;
        logic [PWM_BITS-1:0] active_duty;
        logic [PWM_BITS-1:0] target;
        logic                dir;
        logic                hit;
        logic                led;

        always_comb begin
            hit    = wr_en && wr_ch == CH_W'(g);
            target = mode == 2'b01 ? level :
                     mode == 2'b10 ? phase :
                     (mode == 2'b11 && phase[0]) ? level : '0;
        end

        always_ff @(posedge clk) begin
            if (!rst_n) begin
                mode        <= 2'b00;
                level       <= '0;
                phase       <= '0;
                dir         <= 1'b0;
                active_duty <= '0;
                led         <= 1'b0;
            end else begin
                led <= ena && cnt < active_duty;
                // duty only changes at the period boundary to avoid partial pulses
                if (wrap)
                    active_duty <= target;
                if (hit) begin
                    mode  <= wr_mode;
                    level <= wr_level;
                    phase <= '0;
                    dir   <= 1'b0;
                end else if (fade_step) begin
                    if (mode == 2'b10) begin
                        if (!dir) begin
                            if (phase < level)
                                phase <= phase + 1'b1;
                            else
                                dir <= 1'b1;
                        end else begin
                            if (phase != '0)
                                phase <= phase - 1'b1;
                            else
                                dir <= 1'b0;
                        end
                    end else if (mode == 2'b11) begin
                        phase[0] <= ~phase[0];
                    end
                end
            end
        end

        assign led_out[g] = led;
    end
endmodule

// File: tb/tb_led_pwm_array.sv
// tb_led_pwm_array: directed checks of reset, static, breathe, blink, enable gating and mid-fade reset.
module tb_led_pwm_array;
    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic       ena = 1'b0;
    logic       wr_en = 1'b0;
    logic [1:0] wr_ch = '0;
    logic [1:0] wr_mode = '0;
    logic [7:0] wr_level = '0;
    logic [3:0] led8;
    logic       tick8;
    logic [3:0] led4a;
    logic       tick4a;
    logic [2:0] led4b;
    logic       tick4b;
    int         errors = 0;
    int         checks = 0;
    int         exp_b[10] = '{0, 1, 2, 3, 3, 2, 1, 0, 0, 1};

    always #5 clk = ~clk;

    led_pwm_array d8 (
        .clk(clk), .rst_n(rst_n), .ena(ena), .wr_en(wr_en), .wr_ch(wr_ch),
        .wr_mode(wr_mode), .wr_level(wr_level), .led_out(led8), .period_tick(tick8)
    );

    led_pwm_array #(.NUM_CH(4), .PWM_BITS(4), .FADE_DIV(1)) d4a (
        .clk(clk), .rst_n(rst_n), .ena(ena), .wr_en(wr_en), .wr_ch(wr_ch),
        .wr_mode(wr_mode), .wr_level(wr_level[3:0]), .led_out(led4a), .period_tick(tick4a)
    );

    led_pwm_array #(.NUM_CH(3), .PWM_BITS(4), .FADE_DIV(2)) d4b (
        .clk(clk), .rst_n(rst_n), .ena(ena), .wr_en(wr_en), .wr_ch(wr_ch),
        .wr_mode(wr_mode), .wr_level(wr_level[3:0]), .led_out(led4b), .period_tick(tick4b)
    );

    function automatic logic pick_led(input int sel, input int c);
        return sel == 0 ? led8[c] : sel == 1 ? led4a[c] : led4b[c];
    endfunction

    function automatic logic pick_tick(input int sel);
        return sel == 0 ? tick8 : sel == 1 ? tick4a : tick4b;
    endfunction

    task automatic wr(input logic [1:0] c, input logic [1:0] m, input logic [7:0] lv);
        wr_en = 1'b1;
        wr_ch = c;
        wr_mode = m;
        wr_level = lv;
        @(negedge clk);
        wr_en = 1'b0;
    endtask

    task automatic sync(input int sel);
        int n = 0;
        do begin
            @(negedge clk);
            n++;
        end while (!pick_tick(sel) && n < 1000);
        checks++;
        if (pick_tick(sel) !== 1'b1) begin
            errors++;
            $display("FAIL sync_timeout dut%0d: no period_tick within %0d cycles", sel, n);
        end
    endtask

    // counts high cycles of one channel over the period following the current tick
    task automatic measure(input int sel, input int c, output int h);
        int p = sel == 0 ? 256 : 16;
        h = 0;
        for (int i = 0; i < p; i++) begin
            @(negedge clk);
            h += int'(pick_led(sel, c));
        end
    endtask

    task automatic test_reset;
        int ticks = 0;
        int first = -1;
        int last = -1;
        int gap = -1;
        int bad = 0;
        repeat (3) @(negedge clk);
        checks++;
        if (led8 !== 4'b0) begin errors++; $display("FAIL reset_led8: got %b expected 0000", led8); end
        checks++;
        if (tick8 !== 1'b0) begin errors++; $display("FAIL reset_tick8: got %b expected 0", tick8); end
        checks++;
        if (led4a !== 4'b0) begin errors++; $display("FAIL reset_led4a: got %b expected 0000", led4a); end
        checks++;
        if (led4b !== 3'b0) begin errors++; $display("FAIL reset_led4b: got %b expected 000", led4b); end
        rst_n = 1'b1;
        ena = 1'b1;
        for (int i = 1; i <= 600; i++) begin
            @(negedge clk);
            if (led8 !== 4'b0) bad++;
            if (tick8 === 1'b1) begin
                if (first < 0) first = i;
                else gap = i - last;
                last = i;
                ticks++;
            end
        end
        checks++;
        if (bad != 0) begin errors++; $display("FAIL idle_led: got %0d high cycles expected 0", bad); end
        checks++;
        if (ticks != 2) begin errors++; $display("FAIL idle_tick_count: got %0d expected 2", ticks); end
        checks++;
        if (first != 256) begin errors++; $display("FAIL first_tick: got cycle %0d expected 256", first); end
        checks++;
        if (gap != 256) begin errors++; $display("FAIL tick_spacing: got %0d expected 256", gap); end
    endtask

    task automatic test_static;
        int h;
        int lv[3] = '{64, 0, 255};
        for (int k = 0; k < 3; k++) begin
            wr(2'd1, 2'b01, 8'(lv[k]));
            sync(0);
            for (int p = 0; p < 2; p++) begin
                measure(0, 1, h);
                checks++;
                if (h != lv[k]) begin
                    errors++;
                    $display("FAIL static_duty lvl%0d p%0d: got %0d expected %0d", lv[k], p, h, lv[k]);
                end
            end
        end
        measure(0, 0, h);
        checks++;
        if (h != 0) begin errors++; $display("FAIL static_other_ch: got %0d expected 0", h); end
    endtask

    task automatic test_breathe;
        int h;
        wr(2'd0, 2'b10, 8'd3);
        sync(1);
        for (int i = 0; i < 10; i++) begin
            measure(1, 0, h);
            checks++;
            if (h != exp_b[i]) begin
                errors++;
                $display("FAIL breathe_duty p%0d: got %0d expected %0d", i, h, exp_b[i]);
            end
        end
    endtask

    task automatic test_blink;
        int d[13];
        int k = -1;
        int e;
        wr(2'd2, 2'b11, 8'd10);
        sync(2);
        for (int i = 0; i < 8; i++) measure(2, 2, d[i]);
        checks++;
        if (d[0] != 0) begin errors++; $display("FAIL blink_first: got %0d expected 0", d[0]); end
        for (int j = 2; j >= 1; j--) if (d[j] == 10) k = j;
        checks++;
        if (k < 0) begin
            errors++;
            $display("FAIL blink_start: got %0d,%0d expected 10 within two periods", d[1], d[2]);
            k = 1;
        end
        for (int j = k; j < 8; j++) begin
            e = ((j - k) / 2) % 2 == 0 ? 10 : 0;
            checks++;
            if (d[j] != e) begin errors++; $display("FAIL blink_duty p%0d: got %0d expected %0d", j, d[j], e); end
        end
        // channel 3 does not exist on this 3-channel instance
        wr(2'd3, 2'b01, 8'd5);
        sync(2);
        for (int j = 9; j < 13; j++) begin
            measure(2, 2, d[j]);
            e = ((j - k) / 2) % 2 == 0 ? 10 : 0;
            checks++;
            if (d[j] != e) begin errors++; $display("FAIL blink_after_bad_wr p%0d: got %0d expected %0d", j, d[j], e); end
        end
    endtask

    task automatic test_ena;
        int h;
        int bad = 0;
        int n = 0;
        int exp_pre[3] = '{0, 1, 2};
        int exp_post[3] = '{3, 2, 1};
        wr(2'd0, 2'b10, 8'd3);
        sync(1);
        for (int i = 0; i < 3; i++) begin
            measure(1, 0, h);
            checks++;
            if (h != exp_pre[i]) begin errors++; $display("FAIL ena_pre p%0d: got %0d expected %0d", i, h, exp_pre[i]); end
        end
        repeat (5) @(negedge clk);
        ena = 1'b0;
        repeat (20) begin
            @(negedge clk);
            if (led4a !== 4'b0 || tick4a !== 1'b0 || led8 !== 4'b0 || tick8 !== 1'b0) bad++;
        end
        checks++;
        if (bad != 0) begin errors++; $display("FAIL ena_low_outputs: got %0d active cycles expected 0", bad); end
        ena = 1'b1;
        do begin
            @(negedge clk);
            n++;
        end while (tick4a !== 1'b1 && n < 100);
        checks++;
        if (n != 11) begin errors++; $display("FAIL ena_resume_cnt: got tick after %0d cycles expected 11", n); end
        for (int i = 0; i < 3; i++) begin
            measure(1, 0, h);
            checks++;
            if (h != exp_post[i]) begin errors++; $display("FAIL ena_post p%0d: got %0d expected %0d", i, h, exp_post[i]); end
        end
    endtask

    task automatic test_reset_mid;
        int h;
        int bad = 0;
        wr(2'd0, 2'b10, 8'd3);
        sync(1);
        for (int i = 0; i < 3; i++) measure(1, 0, h);
        rst_n = 1'b0;
        @(negedge clk);
        rst_n = 1'b1;
        checks++;
        if (led4a !== 4'b0) begin errors++; $display("FAIL mid_reset_led4a: got %b expected 0000", led4a); end
        checks++;
        if (tick4a !== 1'b0 || tick8 !== 1'b0) begin
            errors++;
            $display("FAIL mid_reset_tick: got %b%b expected 00", tick4a, tick8);
        end
        checks++;
        if (led8 !== 4'b0 || led4b !== 3'b0) begin
            errors++;
            $display("FAIL mid_reset_other: got %b/%b expected 0000/000", led8, led4b);
        end
        repeat (60) begin
            @(negedge clk);
            if (led4a !== 4'b0 || led4b !== 3'b0) bad++;
        end
        checks++;
        if (bad != 0) begin errors++; $display("FAIL mid_reset_modes_off: got %0d high cycles expected 0", bad); end
        sync(1);
        wr(2'd0, 2'b10, 8'd3);
        sync(1);
        for (int i = 0; i < 3; i++) begin
            measure(1, 0, h);
            checks++;
            if (h != exp_b[i]) begin errors++; $display("FAIL restart_duty p%0d: got %0d expected %0d", i, h, exp_b[i]); end
        end
    endtask

    initial begin
        test_reset;
        test_static;
        test_breathe;
        test_blink;
        test_ena;
        test_reset_mid;
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule

// File: doc/led_pwm_array.md
# led_pwm_array

Parametrised multi-channel LED PWM controller with per-channel static, breathe (triangle fade) and blink modes. It replaces the fixed single-mode LED driver inside the LED-controller user project. The TT wrapper drives its register-write port from `ui_in`/`uio_in` and routes `led_out` to `uo_out`. All channels share one PWM counter and one fade-step timebase, so their outputs are phase-aligned.

## Interface
Parameters:
- `NUM_CH`, 4: number of LED channels, 1..8.
- `PWM_BITS`, 8: PWM counter and level width; period = 2^PWM_BITS cycles.
- `FADE_DIV`, 16: PWM periods per fade/blink step, ≥1.

Ports:
- `clk`  in  1  single clock.
- `rst_n`  in  1  synchronous active-low reset.
- `ena`  in  1  global enable; low freezes timing and forces outputs low.
- `wr_en`  in  1  register write strobe, one cycle.
- `wr_ch`  in  max(1,$clog2(NUM_CH))  target channel.
- `wr_mode`  in  2  mode: 00 OFF, 01 STATIC, 10 BREATHE, 11 BLINK.
- `wr_level`  in  PWM_BITS  target brightness.
- `led_out`  out  NUM_CH  PWM outputs, registered.
- `period_tick`  out  1  one-cycle pulse on the last cycle of each PWM period, registered.

## Operation
- `cnt` (PWM_BITS) increments each cycle while `ena`=1 and wraps from 2^PWM_BITS−1 to 0. A wrap cycle is `cnt`==max with `ena`=1.
- `fdiv` (0..FADE_DIV−1) increments on each wrap cycle and wraps to 0. `fade_step` = wrap cycle with `fdiv`==FADE_DIV−1.
- Per-channel state: `mode`, `level`, `phase` (PWM_BITS), `dir` (0=up), `active_duty` (PWM_BITS).
- Write (`wr_en`=1, `wr_ch`<NUM_CH): loads `mode` and `level`, sets `phase`=0 and `dir`=up. A write with `wr_ch`≥NUM_CH is ignored. Writes are accepted regardless of `ena`.
- Target duty per mode:
  - OFF: 0.
  - STATIC: `level`.
  - BREATHE: `phase`.
  - BLINK: `phase[0]` ? `level` : 0.
- On `fade_step`, unless the channel is written that same cycle (the write wins):
  - BREATHE, up: if `phase`<`level` then `phase`+1, else `dir`←down and `phase` unchanged.
  - BREATHE, down: if `phase`>0 then `phase`−1, else `dir`←up and `phase` unchanged. Endpoints therefore hold for one extra step.
  - If `level` is rewritten below `phase`, the channel turns down on the next step. A write already resets `phase` to 0, so this only arises from the down-branch rule.
  - BLINK: `phase[0]` toggles.
  - OFF/STATIC: no change.
- `active_duty` loads the target duty only on a wrap cycle. This makes duty changes glitch-free at period boundaries.
- `led_out[i]` ← `ena` & (`cnt` < `active_duty[i]`). Duty 0 is always off. Duty max gives 2^PWM_BITS−1 high cycles per period, never 100%.
- `period_tick` ← wrap-cycle condition.
- `ena`=0: `cnt`, `fdiv`, `phase` and `dir` hold; `led_out` and `period_tick` go 0 on the next edge.
- Reset (any cycle, including mid-fade) clears `cnt`, `fdiv`, all channel state and all outputs to 0, with every mode set to OFF.

## Timing
- All outputs are registered. Reset values: `led_out`=0, `period_tick`=0.
- Write at edge t updates channel registers at t+1. The new duty reaches `led_out` at the first period starting after the next wrap cycle.
- `led_out` reflects `cnt` from the previous cycle: 1-cycle latency. `period_tick` is high on the cycle `cnt` reads 0.
- BREATHE full cycle for a fixed `level`=L>0: 2·(L+1) fade steps, i.e. 2·(L+1)·FADE_DIV PWM periods.
- BLINK half-period: FADE_DIV PWM periods.

## Test plan
- Reset, then `ena`=1 for 600 cycles with no writes → `led_out`=0 throughout; `period_tick` pulses every 256 cycles (PWM_BITS=8).
- Write ch1 STATIC `level`=64 → from the next full period, `led_out[1]` is high for 64 of every 256 cycles. Repeat with 0 (never high) and 255 (255 of 256).
- PWM_BITS=4, FADE_DIV=1: ch0 BREATHE `level`=3 → per-period duty sequence 0,1,2,3,3,2,1,0,0,1…
- BLINK `level`=10, FADE_DIV=2, PWM_BITS=4 → duty alternates 10 and 0 every 2 periods. A write to `wr_ch`=NUM_CH leaves all channels unchanged.
- Drop `ena` mid-period for 20 cycles → `led_out`=0 and no `period_tick`. After re-enable, `cnt` resumes from its held value and the breathe sequence continues unbroken.
- Assert `rst_n`=0 for 1 cycle mid-breathe → next cycle all outputs are 0 and all modes are OFF. A subsequent write restarts the channel at `phase`=0.
